// File: rtl/cosim_misr_capture.sv
// Captures a run of DUT output vectors into a WIDTH-bit MISR signature.
// A run is started from IDLE, accepts num_vec vectors, then pulses done for one cycle.
module cosim_misr_capture #(
    parameter int WIDTH = 128,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sig,
    output logic [CNT_W-1:0] vec_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Feedback taps x^7+x^2+x+1, zero-extended to the signature width.
    localparam logic [WIDTH-1:0] FB_POLY  = {{(WIDTH-8){1'b0}}, 8'h87};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] misr_next(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] din
    );
        logic [WIDTH-1:0] fb;
        fb = cur[WIDTH-1] ? FB_POLY : {WIDTH{1'b0}};
        return {cur[WIDTH-2:0], 1'b0} ^ fb ^ din;
    endfunction

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] sig_q,       sig_d;
    logic [CNT_W-1:0] vec_count_q, vec_count_d;
    logic [CNT_W-1:0] num_vec_q,   num_vec_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic             accept_s;
    logic [CNT_W-1:0] cnt_inc_s;

    assign in_ready  = (state_q == ST_RUN);
    assign accept_s  = in_valid & in_ready;
    assign cnt_inc_s = vec_count_q + CNT_ONE;

    // Next-state and datapath update for the capture FSM.
    always_comb begin
        state_d     = state_q;
        sig_d       = sig_q;
        vec_count_d = vec_count_q;
        num_vec_d   = num_vec_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sig_d       = {WIDTH{1'b0}};
                    vec_count_d = CNT_ZERO;
                    num_vec_d   = num_vec;
                    state_d     = (num_vec != CNT_ZERO) ? ST_RUN : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s) begin
                    sig_d       = misr_next(sig_q, in_data);
                    vec_count_d = cnt_inc_s;
                    state_d     = (cnt_inc_s == num_vec_q) ? ST_DONE : ST_RUN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State, signature and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sig_q       <= {WIDTH{1'b0}};
            vec_count_q <= CNT_ZERO;
            num_vec_q   <= CNT_ZERO;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sig_q       <= sig_d;
            vec_count_q <= vec_count_d;
            num_vec_q   <= num_vec_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sig       = sig_q;
    assign vec_count = vec_count_q;

endmodule

// File: doc/cosim_misr_capture.md
COSIM_MISR_CAPTURE -- requirements
Module: cosim_misr_capture

Interface
REQ-001 Parameter WIDTH, default 128, sets the width of the captured DUT output vector and of the signature.
REQ-002 Parameter CNT_W, default 16, sets the width of the vector-count fields.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port start, input, 1, request to begin a capture run.
REQ-006 Port num_vec, input, CNT_W, number of vectors in the run; sampled only on an accepted start.
REQ-007 Port in_valid, input, 1, upstream DUT output vector is present.
REQ-008 Port in_data, input, WIDTH, DUT output vector (the 128-bit out of the cosim spec module).
REQ-009 Port in_ready, output, 1, block accepts a vector this cycle.
REQ-010 Port busy, output, 1, high while a run is in progress (RUN state).
REQ-011 Port done, output, 1, single-cycle pulse marking run completion.
REQ-012 Port sig, output, WIDTH, current MISR signature.
REQ-013 Port vec_count, output, CNT_W, number of vectors accepted in the current or last run.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 In IDLE, start=1 SHALL clear sig and vec_count to 0 and latch num_vec.
- Next state is RUN if num_vec!=0, else DONE.
REQ-016 start SHALL be ignored in RUN and DONE; no queuing.
REQ-017 in_ready SHALL equal 1 exactly when state is RUN; it is combinational from state only and does not depend on in_valid.
REQ-018 A vector is accepted on a cycle with in_valid=1 and in_ready=1; only accepted vectors update sig or vec_count.
REQ-019 On acceptance, sig SHALL become ({sig[WIDTH-2:0],1'b0} ^ (sig[WIDTH-1] ? 'h87 : 0) ^ in_data), i.e. polynomial x^128+x^7+x^2+x+1.
- The feedback constant is zero-extended to WIDTH.
REQ-020 On acceptance, vec_count SHALL increment by 1, with arithmetic modulo 2^CNT_W.
REQ-021 On the acceptance where vec_count+1 equals the latched num_vec, the next state SHALL be DONE.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-023 sig and vec_count SHALL hold their values in DONE and IDLE until the next accepted start.
REQ-024 Cycles in RUN with in_valid=0 SHALL leave all state unchanged; gaps are unbounded.
REQ-025 Latency: done SHALL assert in the cycle immediately after the final acceptance, and sig is final in that same cycle.
REQ-026 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE; the two are never high together.
REQ-027 in_data SHALL be treated as opaque bits; no X filtering or masking.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for a clock edge, force state IDLE, sig=0, vec_count=0, latched num_vec=0, busy=0, done=0, in_ready=0.
REQ-029 Reset asserted mid-run SHALL abandon the run with no done pulse; the first start after deassertion begins a fresh run.
REQ-030 Reset deassertion SHALL take effect at the first rising clk edge at which rst_n is sampled high.

Verification
REQ-031 Reset check: assert rst_n=0 with no clock running -> sig=0, vec_count=0, busy=0, done=0, in_ready=0.
REQ-032 Basic run: start with num_vec=2, accept 128'h1 then 128'h0 -> sig=128'h2, vec_count=2, done high for exactly one cycle after the second accept.
REQ-033 Feedback: num_vec=2, accept 128'h8000_0000_0000_0000_0000_0000_0000_0000 then 128'h0 -> sig=128'h87.
REQ-034 Zero-length run: start with num_vec=0 -> no in_ready, done pulses on the next cycle, sig=0, vec_count=0.
REQ-035 Stalls and ignored start: num_vec=1 with in_valid low for 5 cycles, start pulsed during RUN, then accept 128'hA5 -> sig=128'hA5, exactly one done, and the stray start is ignored.
REQ-036 Mid-run reset: num_vec=4, reset after 2 accepts -> all outputs 0 and no done; a new run with num_vec=1 and data 128'h3 -> sig=128'h3.
